// File: rtl/pid_err_track_if.sv
// pid_err_track_if: sample-in / error-out bundle between capture logic, error tracker and PID gain stage
interface pid_err_track_if #(
    parameter int DATA_W = 10,
    parameter int ERR_W  = 10,
    parameter int NCH    = 4,
    parameter int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
);
    logic                     in_valid;
    logic [CH_W-1:0]          in_ch;
    logic                     in_clr;
    logic signed [DATA_W-1:0] target;
    logic signed [DATA_W-1:0] y;
    logic                     out_valid;
    logic [CH_W-1:0]          out_ch;
    logic signed [ERR_W-1:0]  ek0;
    logic signed [ERR_W-1:0]  ek1;
    logic signed [ERR_W-1:0]  ek2;
    logic signed [ERR_W:0]    de1;
    logic signed [ERR_W+1:0]  de2;
    logic                     sat;

    modport master (
        output in_valid, in_ch, in_clr, target, y,
        input  out_valid, out_ch, ek0, ek1, ek2, de1, de2, sat
    );

    modport slave (
        input  in_valid, in_ch, in_clr, target, y,
        output out_valid, out_ch, ek0, ek1, ek2, de1, de2, sat
    );
endinterface

// File: rtl/pid_err_track.sv
// pid_err_track: per-channel dead-banded, saturated PID error with e(k-1)/e(k-2) history and differences
module pid_err_track #(
    parameter int          DATA_W   = 10,
    parameter int          ERR_W    = 10,
    parameter int          NCH      = 4,
    parameter int          CH_W     = (NCH > 1) ? $clog2(NCH) : 1,
    parameter int unsigned DEADBAND = 0
) (
    input logic            clk,
    input logic            rst_n,
    pid_err_track_if.slave bus
);
    // History is sized to the full index range so any in_ch value is a legal index;
    // entries at or above NCH are never written and stay at their reset value.
    localparam int DEPTH = 1 << CH_W;
    localparam int EMAX_I = (1 << (ERR_W - 1)) - 1;
    localparam logic signed [DATA_W:0] EMAX = EMAX_I[DATA_W:0];
    localparam logic signed [DATA_W:0] EMIN = ~EMAX;
    localparam logic [CH_W:0] NCH_V = (CH_W + 1)'(NCH);

    logic signed [ERR_W-1:0] h1_q [DEPTH];
    logic signed [ERR_W-1:0] h2_q [DEPTH];

    logic                    out_valid_q, out_valid_d;
    logic [CH_W-1:0]         out_ch_q;
    logic signed [ERR_W-1:0] ek0_q, ek1_q, ek2_q;
    logic signed [ERR_W-1:0] ek0_d, ek1_d, ek2_d;
    logic signed [ERR_W:0]   de1_q, de1_d;
    logic signed [ERR_W+1:0] de2_q, de2_d;
    logic                    sat_q, sat_d;

    logic signed [DATA_W:0]  raw_e;
    logic [DATA_W:0]         mag;
    logic                    in_db;
    logic signed [DATA_W:0]  r_db;
    logic                    hi, lo;
    logic signed [DATA_W:0]  e_w;

    // Error path: exact difference, deadband on the magnitude, then clip to the error width.
    // History is read straight from the flops, so a back-to-back sample on the same
    // channel already sees the value written at the previous edge without a bypass.
    always_comb begin
        raw_e       = (DATA_W + 1)'(bus.target) - (DATA_W + 1)'(bus.y);
        mag         = raw_e[DATA_W] ? -raw_e : raw_e;
        in_db       = 32'(mag) <= DEADBAND;
        r_db        = in_db ? '0 : raw_e;
        hi          = r_db > EMAX;
        lo          = r_db < EMIN;
        e_w         = hi ? EMAX : lo ? EMIN : r_db;
        ek0_d       = e_w[ERR_W-1:0];
        sat_d       = hi | lo;
        out_valid_d = bus.in_valid && ({1'b0, bus.in_ch} < NCH_V);
        ek1_d       = bus.in_clr ? '0 : h1_q[bus.in_ch];
        ek2_d       = bus.in_clr ? '0 : h2_q[bus.in_ch];
        de1_d       = (ERR_W + 1)'(ek0_d) - (ERR_W + 1)'(ek1_d);
        de2_d       = (ERR_W + 2)'(ek0_d) - ((ERR_W + 2)'(ek1_d) <<< 1) + (ERR_W + 2)'(ek2_d);
    end

    // Per-channel history shift on every accepted sample; a clear seeds e(k-2) with zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                h1_q[i] <= '0;
                h2_q[i] <= '0;
            end
        end else if (out_valid_d) begin
            h1_q[bus.in_ch] <= ek0_d;
            h2_q[bus.in_ch] <= ek1_d;
        end
    end

    // Result registers: pulse valid per accepted sample, otherwise hold the last result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            ek0_q       <= '0;
            ek1_q       <= '0;
            ek2_q       <= '0;
            de1_q       <= '0;
            de2_q       <= '0;
            sat_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (out_valid_d) begin
                out_ch_q <= bus.in_ch;
                ek0_q    <= ek0_d;
                ek1_q    <= ek1_d;
                ek2_q    <= ek2_d;
                de1_q    <= de1_d;
                de2_q    <= de2_d;
                sat_q    <= sat_d;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.ek0       = ek0_q;
    assign bus.ek1       = ek1_q;
    assign bus.ek2       = ek2_q;
    assign bus.de1       = de1_q;
    assign bus.de2       = de2_q;
    assign bus.sat       = sat_q;
endmodule

// File: doc/pid_err_track.md
# pid_err_track

Multi-channel error tracker for the incremental PID datapath. For each sample it computes the saturated, dead-banded error e(k) = target − y for one of NCH time-multiplexed loops and keeps a per-channel e(k−1)/e(k−2) history. It also produces the first and second differences consumed by the PID multiply-accumulate stage. It sits between the sensor/target capture logic and the PID gain stage, and replaces the single-channel free-running error register.

## Interface
- DATA_W, 10: signed width of target and y.
- ERR_W, 10: signed width of stored/output errors; must satisfy ERR_W ≤ DATA_W+1.
- NCH, 4: number of independent channels, 1..16.
- CH_W, $clog2(NCH) (min 1): channel index width.
- DEADBAND, 0: unsigned magnitude; any |e| ≤ DEADBAND is forced to 0.
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  sample strobe; one sample per asserted cycle.
- in_ch  in  CH_W  channel of the sample.
- in_clr  in  1  with in_valid: clear that channel's history before use.
- target  in  DATA_W  signed setpoint.
- y  in  DATA_W  signed measured value.
- out_valid  out  1  result valid, single-cycle pulse.
- out_ch  out  CH_W  channel of the result.
- ek0 / ek1 / ek2  out  ERR_W each  signed e(k), e(k−1), e(k−2).
- de1  out  ERR_W+1  signed ek0 − ek1.
- de2  out  ERR_W+2  signed ek0 − 2·ek1 + ek2.
- sat  out  1  ek0 was clipped by saturation.

## Operation
- Raw error: r = target − y, computed sign-extended in DATA_W+1 bits with no overflow.
- Deadband: if |r| ≤ DEADBAND, then r = 0. The deadband is applied before saturation, and sat = 0 in that case.
- Saturation: clip r to [−2^(ERR_W−1), 2^(ERR_W−1)−1]. sat = 1 when clipping occurred. The result is e.
- History storage: per channel c, two registers h1[c] = e(k−1) and h2[c] = e(k−2).
- Accepted sample (in_valid=1, in_ch < NCH):
  - If in_clr=0: ek1 = h1[in_ch], ek2 = h2[in_ch].
  - If in_clr=1: ek1 = ek2 = 0.
  - Update: h1[in_ch] ← e; h2[in_ch] ← (in_clr ? 0 : old h1[in_ch]).
- de1/de2: computed from the emitted ek0/ek1/ek2 at full width. They never wrap.
- Out-of-range channel (in_ch ≥ NCH, possible only when NCH is not a power of 2): the sample is dropped. No out_valid, no history change, outputs hold.
- Idle (in_valid=0): no state change. ek*/de*/sat/out_ch hold their last values; out_valid=0.
- Channels are fully independent. A sample on channel c never alters the history of any other channel.

## Timing
- Reset (asynchronous, takes effect immediately): all h1/h2 = 0, out_valid=0, out_ch=0, ek0/ek1/ek2/de1/de2=0, sat=0.
- Latency: 1 cycle. A sample accepted at edge N produces registered outputs and out_valid=1 after edge N+1.
- Throughput: 1 sample/cycle, with no back-pressure. Back-to-back samples on the same channel must see the history written by the previous sample. No stall or bubble is allowed; a bypass is required if history reads are registered.
- Reset deasserted mid-stream: the first accepted sample per channel after release reports ek1=ek2=0.
- in_clr on a channel with empty history behaves identically to in_clr=0.

## Test plan
- DATA_W=10, ERR_W=10, NCH=4, DEADBAND=2. Channel 0 samples, each (target, y):
  - (100,90) -> ek0=10, ek1=0, ek2=0, de1=10, de2=10.
  - (100,95) -> 5, 10, 0; de1=−5, de2=−15.
  - (100,99) -> ek0=0 (deadband), ek1=5, ek2=10; de1=−5, de2=0; sat=0 throughout.
- Saturation: (511,−512) -> ek0=511, sat=1. Next (−512,511) -> ek0=−512, sat=1, ek1=511, de1=−1023, de2=−1534.
- Interleave, back-to-back cycles: ch1 e=20, ch2 e=−30, ch1 e=25 -> the third result has out_ch=1, ek0=25, ek1=20, ek2=0. Channel 2 history is unaffected (next ch2 sample reports ek1=−30).
- Clear: ch0 history (5,10). Sample with in_clr=1, e=7 -> ek0=7, ek1=0, ek2=0. Next sample e=8 -> ek1=7, ek2=0.
- Reset mid-stream: pull rst_n low between two ch0 samples. out_valid drops immediately and all outputs read 0. The first sample after release reports ek1=ek2=0.
- NCH=3 with in_ch=3 and in_valid=1 -> no out_valid and outputs unchanged. A following ch0 sample reports the correct prior history.
